// File: rtl/psram_pkg.sv
// Shared types and helpers for the psram round-robin arbiter.
package psram_pkg;

    typedef enum logic [2:0] {
        DRAIN = 3'd0,
        IDLE  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } arb_state_t;

    // Width of a counter that must reach MEM_CYCLES.
    function automatic int cnt_width(input int mem_cycles);
        return $clog2(mem_cycles + 1);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping at NUM_REQ.
module rr_priority_picker #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic                       any_o,
    output logic [$clog2(NUM_REQ)-1:0] winner_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] idx;

    // Scan offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        any_o    = 1'b0;
        winner_o = '0;
        idx      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
            if (req_i[idx]) begin
                any_o    = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/psram_arbiter.sv
// Round-robin arbiter sharing one psram controller between NUM_REQ
// requesters. The controller has no busy flag, so every access is a
// fixed-length, time-based sequence with a single transaction in flight.
//
// state | meaning
// DRAIN | wait MEM_CYCLES after reset for a possibly busy controller
// IDLE  | sample requests, latch the round-robin winner
// ISSUE | one-cycle rd/wr enable to the controller, ready to winner
// WAIT  | count MEM_CYCLES, capture read data on the last count
// DONE  | one-cycle response strobe to the winner
module psram_arbiter
    import psram_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int ADDRESS_BITS = 23,
    parameter int DATA_BITS    = 16,
    parameter int MEM_CYCLES   = 6
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ-1:0]                    req_write,
    input  logic [NUM_REQ-1:0][ADDRESS_BITS-1:0]  req_address,
    input  logic [NUM_REQ-1:0][DATA_BITS-1:0]     req_wr_data,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic [NUM_REQ-1:0]                    resp_valid,
    output logic [DATA_BITS-1:0]                  resp_rd_data,
    output logic [ADDRESS_BITS-1:0]               mem_address,
    output logic                                  mem_rd_en,
    output logic                                  mem_wr_en,
    output logic [DATA_BITS-1:0]                  mem_wr_data,
    input  logic [DATA_BITS-1:0]                  mem_rd_data
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(MEM_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_t             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       ptr_q;
    logic [IDX_W-1:0]       ptr_d;
    logic [IDX_W-1:0]       win_q;
    logic                   write_q;
    logic [NUM_REQ-1:0]     req_ready_q;
    logic [NUM_REQ-1:0]     resp_valid_q;
    logic [DATA_BITS-1:0]   resp_rd_data_q;
    logic [ADDRESS_BITS-1:0] mem_address_q;
    logic [DATA_BITS-1:0]   mem_wr_data_q;
    logic                   mem_rd_en_q;
    logic                   mem_wr_en_q;

    logic                   pick_any;
    logic [IDX_W-1:0]       pick_idx;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i    (req_valid),
        .ptr_i    (ptr_q),
        .any_o    (pick_any),
        .winner_o (pick_idx)
    );

    // Next pointer: one past the current winner, wrapping at NUM_REQ.
    assign ptr_d = (win_q == IDX_LAST) ? '0 : win_q + IDX_W'(1);

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= DRAIN;
            cnt_q          <= '0;
            ptr_q          <= '0;
            win_q          <= '0;
            write_q        <= 1'b0;
            req_ready_q    <= '0;
            resp_valid_q   <= '0;
            resp_rd_data_q <= '0;
            mem_address_q  <= '0;
            mem_wr_data_q  <= '0;
            mem_rd_en_q    <= 1'b0;
            mem_wr_en_q    <= 1'b0;
        end else begin
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            mem_rd_en_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            case (state_q)
                DRAIN: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                IDLE: begin
                    if (pick_any) begin
                        win_q                 <= pick_idx;
                        write_q               <= req_write[pick_idx];
                        mem_address_q         <= req_address[pick_idx];
                        mem_wr_data_q         <= req_wr_data[pick_idx];
                        req_ready_q[pick_idx] <= 1'b1;
                        mem_rd_en_q           <= ~req_write[pick_idx];
                        mem_wr_en_q           <= req_write[pick_idx];
                        state_q               <= ISSUE;
                    end
                end
                ISSUE: begin
                    ptr_q   <= ptr_d;
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        if (!write_q) begin
                            resp_rd_data_q <= mem_rd_data;
                        end
                        resp_valid_q[win_q] <= 1'b1;
                        state_q             <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= DRAIN;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rd_data = resp_rd_data_q;
    assign mem_address  = mem_address_q;
    assign mem_wr_data  = mem_wr_data_q;
    assign mem_rd_en    = mem_rd_en_q;
    assign mem_wr_en    = mem_wr_en_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Bench for psram_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level model of the arbiter and
// a behavioural psram controller.
module tb_psram_arbiter;

    localparam int NUM_REQ      = 3;
    localparam int ADDRESS_BITS = 23;
    localparam int DATA_BITS    = 16;
    localparam int MEM_CYCLES   = 6;

    logic                                 clk;
    logic                                 reset;
    logic [NUM_REQ-1:0]                   req_valid;
    logic [NUM_REQ-1:0]                   req_write;
    logic [NUM_REQ-1:0][ADDRESS_BITS-1:0] req_address;
    logic [NUM_REQ-1:0][DATA_BITS-1:0]    req_wr_data;
    logic [NUM_REQ-1:0]                   req_ready;
    logic [NUM_REQ-1:0]                   resp_valid;
    logic [DATA_BITS-1:0]                 resp_rd_data;
    logic [ADDRESS_BITS-1:0]              mem_address;
    logic                                 mem_rd_en;
    logic                                 mem_wr_en;
    logic [DATA_BITS-1:0]                 mem_wr_data;
    logic [DATA_BITS-1:0]                 mem_rd_data;

    psram_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .ADDRESS_BITS (ADDRESS_BITS),
        .DATA_BITS    (DATA_BITS),
        .MEM_CYCLES   (MEM_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_address  (req_address),
        .req_wr_data  (req_wr_data),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_rd_data (resp_rd_data),
        .mem_address  (mem_address),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_data  (mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Transaction-level model state.
    int                    m_ptr, m_next_ok, m_resp_cyc, m_idx;
    bit                    m_pend, m_is_rd;
    logic [DATA_BITS-1:0]  m_data, m_last_rd, m_wd;
    logic [ADDRESS_BITS-1:0] m_addr;
    logic [DATA_BITS-1:0]  ref_mem [logic [ADDRESS_BITS-1:0]];

    // Behavioural controller state.
    logic [DATA_BITS-1:0]  ctrl_mem [logic [ADDRESS_BITS-1:0]];
    logic [DATA_BITS-1:0]  ctrl_val;
    int                    ctrl_age;

    // Observations.
    int obs_g[$];
    int obs_gc[$];
    int ready0_cnt, resp_cnt, wr_cnt;

    function automatic logic [DATA_BITS-1:0] mem_default(input logic [ADDRESS_BITS-1:0] a);
        if (a == 23'h000123) return 16'hBEEF;
        return a[15:0] ^ 16'hA5C3;
    endfunction

    function automatic logic [DATA_BITS-1:0] ref_lookup(input logic [ADDRESS_BITS-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic int first_set(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: update the model, compare every output, run the controller.
    task automatic step();
        logic [NUM_REQ-1:0] exp_ready, exp_resp;
        logic               exp_rd, exp_wr;
        int                 w;
        @(negedge clk);
        cyc++;
        exp_ready = '0;
        exp_resp  = '0;
        exp_rd    = 1'b0;
        exp_wr    = 1'b0;
        if (reset) begin
            m_ptr     = 0;
            m_pend    = 1'b0;
            m_last_rd = '0;
            m_addr    = '0;
            m_wd      = '0;
            m_next_ok = cyc + MEM_CYCLES + 1;
        end else begin
            if (cyc >= m_next_ok && req_valid != '0) begin
                w            = rr_pick(req_valid, m_ptr);
                exp_ready[w] = 1'b1;
                exp_rd       = ~req_write[w];
                exp_wr       = req_write[w];
                m_addr       = req_address[w];
                m_wd         = req_wr_data[w];
                m_ptr        = (w + 1) % NUM_REQ;
                m_pend       = 1'b1;
                m_idx        = w;
                m_is_rd      = ~req_write[w];
                m_resp_cyc   = cyc + MEM_CYCLES + 1;
                m_next_ok    = cyc + MEM_CYCLES + 3;
                if (req_write[w]) ref_mem[m_addr] = m_wd;
                else m_data = ref_lookup(m_addr);
            end
            if (m_pend && cyc == m_resp_cyc) begin
                exp_resp[m_idx] = 1'b1;
                m_pend          = 1'b0;
                if (m_is_rd) m_last_rd = m_data;
            end
        end
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("resp_valid", 64'(resp_valid), 64'(exp_resp));
        chk("resp_rd_data", 64'(resp_rd_data), 64'(m_last_rd));
        chk("mem_rd_en", 64'(mem_rd_en), 64'(exp_rd));
        chk("mem_wr_en", 64'(mem_wr_en), 64'(exp_wr));
        chk("mem_address", 64'(mem_address), 64'(m_addr));
        chk("mem_wr_data", 64'(mem_wr_data), 64'(m_wd));
        chk("mem_en_exclusive", 64'(mem_rd_en & mem_wr_en), 64'(0));
        if (req_ready != '0) begin
            obs_g.push_back(first_set(req_ready));
            obs_gc.push_back(cyc);
        end
        if (req_ready[0]) ready0_cnt++;
        if (resp_valid != '0) resp_cnt++;
        if (mem_wr_en) wr_cnt++;
        // Controller: writes land on wr_en, read data settles a few clocks after rd_en.
        if (mem_wr_en) ctrl_mem[mem_address] = mem_wr_data;
        if (mem_rd_en) begin
            ctrl_val = ctrl_mem.exists(mem_address) ? ctrl_mem[mem_address] : mem_default(mem_address);
            ctrl_age = 0;
        end else if (ctrl_age < 255) begin
            ctrl_age++;
        end
        mem_rd_data = (ctrl_age >= 3) ? ctrl_val : DATA_BITS'($urandom);
    endtask

    // Clock plus requester behaviour: drop valid once accepted.
    task automatic tick();
        step();
        for (int r = 0; r < NUM_REQ; r++) begin
            if (req_ready[r]) req_valid[r] = 1'b0;
        end
    endtask

    task automatic set_req(input int r, input logic wr, input logic [ADDRESS_BITS-1:0] a,
                           input logic [DATA_BITS-1:0] d);
        req_valid[r]   = 1'b1;
        req_write[r]   = wr;
        req_address[r] = a;
        req_wr_data[r] = d;
    endtask

    task automatic rand_req(input int r);
        set_req(r, 1'($urandom), ADDRESS_BITS'($urandom) & 23'h40000F, DATA_BITS'($urandom));
    endtask

    task automatic wait_ready(input int r, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!req_ready[r] && lat < 60);
        chk($sformatf("ready%0d_arrived", r), 64'(req_ready[r]), 64'(1));
    endtask

    task automatic wait_resp(input int r, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!resp_valid[r] && lat < 60);
        chk($sformatf("resp%0d_arrived", r), 64'(resp_valid[r]), 64'(1));
    endtask

    initial begin
        int lat, g0, r0_before, resp_before, wr_before;
        reset       = 1'b1;
        req_valid   = '0;
        req_write   = '0;
        req_address = '0;
        req_wr_data = '0;
        mem_rd_data = '0;
        ctrl_val    = '0;
        ctrl_age    = 255;
        ready0_cnt  = 0;
        resp_cnt    = 0;
        wr_cnt      = 0;
        repeat (3) step();

        // Read right out of reset: held off by the drain period.
        reset = 1'b0;
        set_req(0, 1'b0, 23'h000123, 16'h0000);
        wait_ready(0, lat);
        chk("t1_drain_latency", 64'(lat), 64'(MEM_CYCLES + 1));
        chk("t1_rd_en", 64'(mem_rd_en), 64'(1));
        chk("t1_rd_addr", 64'(mem_address), 64'(23'h000123));
        wait_resp(0, lat);
        chk("t1_resp_latency", 64'(lat), 64'(MEM_CYCLES + 1));
        chk("t1_rd_data", 64'(resp_rd_data), 64'(16'hBEEF));

        // Bank-1 write from requester 1; read data register must hold.
        wr_before = wr_cnt;
        set_req(1, 1'b1, 23'h400010, 16'h5A5A);
        wait_ready(1, lat);
        chk("t2_wr_en", 64'(mem_wr_en), 64'(1));
        chk("t2_wr_data", 64'(mem_wr_data), 64'(16'h5A5A));
        chk("t2_wr_addr", 64'(mem_address), 64'(23'h400010));
        wait_resp(1, lat);
        chk("t2_resp_latency", 64'(lat), 64'(MEM_CYCLES + 1));
        chk("t2_rd_data_held", 64'(resp_rd_data), 64'(16'hBEEF));
        chk("t2_wr_pulses", 64'(wr_cnt - wr_before), 64'(1));

        // Fresh pointer, all requesters busy: strict rotation.
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        g0 = obs_g.size();
        for (int r = 0; r < NUM_REQ; r++) rand_req(r);
        for (int n = 0; n < 200; n++) begin
            tick();
            if (obs_g.size() - g0 >= 6) break;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!req_valid[r]) rand_req(r);
            end
        end
        req_valid = '0;
        chk("t3_grant_count", 64'(obs_g.size() - g0), 64'(6));
        if (obs_g.size() - g0 >= 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("t3_grant_order_%0d", i), 64'(obs_g[g0 + i]), 64'(i % NUM_REQ));
                if (i > 0)
                    chk($sformatf("t3_grant_spacing_%0d", i),
                        64'(obs_gc[g0 + i] - obs_gc[g0 + i - 1]), 64'(MEM_CYCLES + 3));
            end
        end
        repeat (MEM_CYCLES + 3) tick();

        // Pointer lands on 2 after granting 1; a lone requester 1 still wins.
        rand_req(1);
        wait_ready(1, lat);
        rand_req(1);
        wait_ready(1, lat);
        chk("t4_wrap_winner", 64'(obs_g[obs_g.size() - 1]), 64'(1));
        for (int r = 0; r < NUM_REQ; r++) rand_req(r);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (req_ready == '0 && lat < 60);
        chk("t4_next_ptr_winner", 64'(first_set(req_ready)), 64'(2));
        req_valid = '0;
        repeat (MEM_CYCLES + 3) tick();

        // Reset during WAIT of a read: aborted response never appears.
        set_req(0, 1'b0, 23'h000005, 16'h0000);
        wait_ready(0, lat);
        repeat (3) tick();
        resp_before = resp_cnt;
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_req(2, 1'b0, 23'h000040, 16'h0000);
        wait_ready(2, lat);
        chk("t5_drain_latency", 64'(lat), 64'(MEM_CYCLES + 1));
        chk("t5_no_aborted_resp", 64'(resp_cnt - resp_before), 64'(0));
        wait_resp(2, lat);
        chk("t5_rd_data", 64'(resp_rd_data), 64'(mem_default(23'h000040)));

        // Requester 0 withdraws exactly as requester 2 arrives, pointer at 0.
        rand_req(2);
        wait_ready(2, lat);
        rand_req(0);
        r0_before = ready0_cnt;
        repeat (MEM_CYCLES + 2) tick();
        req_valid[0] = 1'b0;
        rand_req(2);
        wait_ready(2, lat);
        chk("t6_swap_latency", 64'(lat), 64'(1));
        chk("t6_req0_no_ready", 64'(ready0_cnt - r0_before), 64'(0));
        repeat (MEM_CYCLES + 3) tick();

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            tick();
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!req_valid[r] && $urandom_range(0, 3) == 0) rand_req(r);
            end
        end
        req_valid = '0;
        repeat (MEM_CYCLES + 4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
